// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues requests over req/gnt, and buffers in-order responses for decode.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises fetch_misaligned.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction_read,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]      NOP       = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] occupancy;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [31:0]      q_word [DEPTH];
    logic [31:0]      q_pc   [DEPTH];

    logic             halted;
    logic             pop;
    logic             push;
    logic             grant;
    logic [CNT_W:0]   demand;
    logic [31:0]      redirect_target;

    assign redirect_target = redirect_pc & ~32'h3;

    // Slots already committed (queued or in flight) after this cycle's pop must leave room for one more word.
    assign demand = {1'b0, occupancy} + {1'b0, outstanding} - {{CNT_W{1'b0}}, pop};

    assign instr_valid = (occupancy != '0);
    assign pop         = instr_valid && !stall;
    assign imem_req    = !reset && !redirect_valid && !halted && (demand < DEPTH_EXT);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign push        = imem_rvalid && !redirect_valid && (discard == '0);

    assign instruction_read = instr_valid ? q_word[head] : NOP;
    assign instr_pc         = instr_valid ? q_pc[head]   : 32'h0000_0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight belongs to the old path; a response landing now is dropped too.
            fetch_pc    <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - CNT_W'(imem_rvalid);
            discard     <= outstanding - CNT_W'(imem_rvalid);
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
            if (imem_rvalid && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_word[tail] <= imem_rdata;
            q_pc[tail]   <= resp_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    // Any redirect re-evaluates the flag, so the next aligned target clears the halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (redirect_valid) begin
            misaligned_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted           = misaligned_q;
    assign fetch_misaligned = misaligned_q;
`else
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model returning addr+0x100 plus a decode-side PC scoreboard.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction_read;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stall            (stall),
        .instr_valid      (instr_valid),
        .instruction_read (instruction_read),
        .instr_pc         (instr_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    mreq_t       mem_q[$];
    int          cyc;
    int          lat;
    bit          gnt_toggle;
    int          max_out;
    logic [31:0] exp_pc;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive_mem();
        imem_gnt = gnt_toggle ? ((cyc % 3) != 0) : 1'b1;
        if (mem_q.size() != 0 && mem_q[0].ready <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr + 32'h100;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    // One clock: sample handshakes and decode pops at negedge, advance the memory model after the edge.
    task automatic step();
        logic        granted;
        logic        consumed;
        logic [31:0] gaddr;
        @(negedge clk);
        granted  = imem_req && imem_gnt;
        gaddr    = imem_addr;
        consumed = imem_rvalid;
        if (!reset && !redirect_valid && instr_valid && !stall) begin
            check("pop_pc", instr_pc, exp_pc);
            check("pop_word", instruction_read, exp_pc + 32'h100);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            mem_q.delete();
        end else begin
            if (consumed && mem_q.size() != 0) void'(mem_q.pop_front());
            if (granted) mem_q.push_back('{addr: gaddr, ready: cyc + lat - 1});
        end
        if (mem_q.size() > max_out) max_out = mem_q.size();
        drive_mem();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!instr_valid && k < budget) begin
            step();
            k++;
        end
        check(tag, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instruction_read, 32'h0000_0013);
        check({tag, "_pc"}, instr_pc, 32'h0);
        check({tag, "_mis"}, {31'd0, fetch_misaligned}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        lat = 1;
        gnt_toggle = 1'b0;
        max_out = 0;
        exp_pc = 32'h0;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;

        // Reset and release, 1-cycle memory
        run(3);
        check_reset_state("rst");
        reset = 1'b0;
        #1;
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        step();
        check("rel1_valid", {31'd0, instr_valid}, 32'd0);
        check("rel1_addr", imem_addr, 32'h4);
        step();
        check("rel2_valid", {31'd0, instr_valid}, 32'd1);
        check("rel2_pc", instr_pc, 32'h0);
        check("rel2_instr", instruction_read, 32'h100);
        step();
        check("rel3_pc", instr_pc, 32'h4);
        run(6);

        // Stall holds the head, stops requests, drains outstanding
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_head", instr_pc, exp_pc);
            check("stall_out", mem_q.size(), 32'd0);
        end
        stall = 1'b0;
        run(6);

        // Redirect in the same cycle as a response
        check("rv_same_cycle", {31'd0, imem_rvalid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        #1;
        check("rdr1_valid", {31'd0, instr_valid}, 32'd0);
        check("rdr1_req", {31'd0, imem_req}, 32'd1);
        check("rdr1_addr", imem_addr, 32'h200);
        step();
        check("rdr2_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("rdr3_valid", {31'd0, instr_valid}, 32'd1);
        check("rdr3_pc", instr_pc, 32'h200);
        check("rdr3_instr", instruction_read, 32'h300);
        run(4);

        // Redirect while stalled with a full queue
        stall = 1'b1;
        run(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        #1;
        check("rst_stall_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_stall_req", {31'd0, imem_req}, 32'd1);
        check("rst_stall_addr", imem_addr, 32'h300);
        stall = 1'b0;
        wait_valid("rst_stall_wait", 10);
        check("rst_stall_pc", instr_pc, 32'h300);
        check("rst_stall_instr", instruction_read, 32'h400);
        run(4);

        // 3-cycle memory: outstanding bounded by DEPTH
        lat = 3;
        max_out = 0;
        run(20);
        check("max_outstanding", max_out, 32'd2);

        // Redirect with two requests in flight
        begin
            int k;
            k = 0;
            while (mem_q.size() != 2 && k < 10) begin
                step();
                k++;
            end
        end
        check("two_inflight", mem_q.size(), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        #1;
        check("stale_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_addr", imem_addr, 32'h80);
        wait_valid("stale_wait", 20);
        check("stale_pc", instr_pc, 32'h80);
        check("stale_instr", instruction_read, 32'h180);
        run(6);

        // Intermittent grant, 2-cycle memory
        lat = 2;
        gnt_toggle = 1'b1;
        run(24);
        gnt_toggle = 1'b0;
        lat = 1;
        run(6);

        // PC wraps through 2^32
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        run(2);
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", instruction_read, 32'h0000_00F8);
        run(10);
        check("wrap_valid", {31'd0, instr_valid}, 32'd1);
        check("wrap_head", instr_pc, exp_pc);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc = 32'h82;
        step();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
        check("mis_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mis_halt_req", {31'd0, imem_req}, 32'd0);
            check("mis_halt_valid", {31'd0, instr_valid}, 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h90;
        step();
        redirect_valid = 1'b0;
        #1;
        check("mis_clr_flag", {31'd0, fetch_misaligned}, 32'd0);
        check("mis_clr_req", {31'd0, imem_req}, 32'd1);
        check("mis_clr_addr", imem_addr, 32'h90);
        wait_valid("mis_clr_wait", 10);
        check("mis_clr_pc", instr_pc, 32'h90);
`else
        check("mis_flag", {31'd0, fetch_misaligned}, 32'd0);
        check("mis_req", {31'd0, imem_req}, 32'd1);
        check("mis_addr", imem_addr, 32'h80);
        wait_valid("mis_wait", 10);
        check("mis_pc", instr_pc, 32'h80);
        check("mis_instr", instruction_read, 32'h180);
`endif
        run(4);

        // Reset asserted mid-operation
        reset = 1'b1;
        #1;
        mem_q.delete();
        imem_rvalid = 1'b0;
        check_reset_state("midrst");
        run(2);
        reset = 1'b0;
        exp_pc = 32'h0;
        #1;
        check("midrst_rel_req", {31'd0, imem_req}, 32'd1);
        check("midrst_rel_addr", imem_addr, 32'h0);
        wait_valid("midrst_wait", 10);
        check("midrst_pc", instr_pc, 32'h0);
        check("midrst_instr", instruction_read, 32'h100);
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
